// File: rtl/alu_scheduler_if.sv
// Request, shared-ALU and response signal bundle for alu_scheduler.
// slave is the scheduler side; master is the requester/ALU/consumer side.
interface alu_scheduler_if;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_ready;
  logic       req1_ready;
  logic [2:0] req0_opcode;
  logic [2:0] req1_opcode;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_a_m;
  logic [3:0] alu_b_m;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_flag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_flag;

  modport slave (
    input  req0_valid, req1_valid, req0_opcode, req1_opcode,
           req0_a, req0_b, req1_a, req1_b, alu_result, alu_flag, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_a_m, alu_b_m, alu_opcode,
           rsp_valid, rsp_id, rsp_result, rsp_flag
  );

  modport master (
    output req0_valid, req1_valid, req0_opcode, req1_opcode,
           req0_a, req0_b, req1_a, req1_b, alu_result, alu_flag, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_a_m, alu_b_m, alu_opcode,
           rsp_valid, rsp_id, rsp_result, rsp_flag
  );
endinterface

// File: rtl/alu_scheduler.sv
// Two-requester scheduler for one shared multi-cycle ALU (IDLE -> EXEC -> RESP).
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module alu_scheduler #(
  parameter int EXEC_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [3:0] LOAD_VAL = 4'(EXEC_LAT - 1);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] cnt_r;
  logic       last_grant_r;
  logic [2:0] op_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic       rsp_valid_r;
  logic       rsp_id_r;
  logic [7:0] rsp_result_r;
  logic       rsp_flag_r;

  logic       grant_s;
  logic       accept_s;
  logic       capture_s;
  logic       release_s;
  logic [2:0] op_s;
  logic [7:0] a_s;
  logic [7:0] b_s;

  // Pick the requester to serve when the scheduler is free.
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_SCHED_RR_EN
      grant_s = ~last_grant_r;
`else
      grant_s = 1'b0;
`endif
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Operand mux from the granted requester.
  always_comb begin
    if (grant_s) begin
      op_s = bus.req1_opcode;
      a_s  = bus.req1_a;
      b_s  = bus.req1_b;
    end else begin
      op_s = bus.req0_opcode;
      a_s  = bus.req0_a;
      b_s  = bus.req0_b;
    end
  end

  // Next-state and transition strobes.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept_s = 1'b1;
          state_s  = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          capture_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = EXEC;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Ready is combinational so an acceptance can happen in the first cycle after reset.
  assign bus.req0_ready = accept_s && !rst && !grant_s;
  assign bus.req1_ready = accept_s && !rst &&  grant_s;

  // State, latched operation, execution counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      last_grant_r <= 1'b1;
      op_r         <= 3'b000;
      a_r          <= 8'd0;
      b_r          <= 8'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= 8'd0;
      rsp_flag_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r         <= op_s;
        a_r          <= a_s;
        b_r          <= b_s;
        last_grant_r <= grant_s;
        cnt_r        <= LOAD_VAL;
      end else if ((state_r == EXEC) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      // last_grant_r doubles as the id of the operation in flight.
      if (capture_s) begin
        rsp_valid_r  <= 1'b1;
        rsp_id_r     <= last_grant_r;
        rsp_result_r <= bus.alu_result;
        rsp_flag_r   <= bus.alu_flag;
      end else if (release_s) begin
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

  assign bus.alu_a      = a_r;
  assign bus.alu_b      = b_r;
  assign bus.alu_a_m    = a_r[3:0];
  assign bus.alu_b_m    = b_r[3:0];
  assign bus.alu_opcode = op_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_flag   = rsp_flag_r;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: requester drivers, a combinational ALU stub,
// and a cycle-level reference model checked on every falling edge.
module tb_alu_scheduler;
  localparam int LAT = 2;
`ifdef ALU_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct { logic [2:0] op; logic [7:0] a; logic [7:0] b; int gap; } op_t;
  typedef struct { logic id; logic [7:0] res; logic flag; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_scheduler_if bus();
  alu_scheduler #(.EXEC_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic       v   [2];
  logic [2:0] opc [2];
  logic [7:0] oa  [2];
  logic [7:0] ob  [2];
  op_t  q0[$];
  op_t  q1[$];
  rsp_t exp_q[$];
  rsp_t log_q[$];
  int   rr_mode = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  assign bus.req0_valid  = v[0];
  assign bus.req1_valid  = v[1];
  assign bus.req0_opcode = opc[0];
  assign bus.req1_opcode = opc[1];
  assign bus.req0_a      = oa[0];
  assign bus.req0_b      = ob[0];
  assign bus.req1_a      = oa[1];
  assign bus.req1_b      = ob[1];

  function automatic logic [8:0] alu_stub(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] am,
                                          input logic [3:0] bm);
    logic [7:0] r;
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, 8'(am) * 8'(bm)};
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ~(a & b);
      default: r = a;
    endcase
    return {~|r, r};
  endfunction

  assign {bus.alu_flag, bus.alu_result} =
    alu_stub(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_a_m, bus.alu_b_m);

  // Reference arithmetic on plain integers.
  function automatic rsp_t ref_rsp(input logic id, input int op, input int a, input int b);
    int r;
    int f;
    case (op)
      0: begin r = (a + b) % 256;       f = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; f = (a < b) ? 1 : 0; end
      2: begin r = (a % 16) * (b % 16); f = 0; end
      default: begin
        case (op)
          3: r = a & b;
          4: r = a | b;
          5: r = a ^ b;
          6: r = 255 - (a & b);
          default: r = a;
        endcase
        f = (r == 0) ? 1 : 0;
      end
    endcase
    return '{id, r[7:0], f[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic present(input int i);
    op_t t;
    if (i == 0) begin
      if (q0.size() > 0) begin
        t = q0[0];
        if (t.gap > 0) begin t.gap = t.gap - 1; q0[0] = t; end
        else begin v[0] = 1'b1; opc[0] = t.op; oa[0] = t.a; ob[0] = t.b; end
      end
    end else begin
      if (q1.size() > 0) begin
        t = q1[0];
        if (t.gap > 0) begin t.gap = t.gap - 1; q1[0] = t; end
        else begin v[1] = 1'b1; opc[1] = t.op; oa[1] = t.a; ob[1] = t.b; end
      end
    end
  endtask

  // Requester drivers: keep valid up until taken, then move to the next queued op.
  initial begin
    logic took [2];
    for (int i = 0; i < 2; i++) begin v[i] = 1'b0; opc[i] = 3'd0; oa[i] = 8'd0; ob[i] = 8'd0; end
    forever begin
      @(negedge clk);
      took[0] = v[0] && bus.req0_ready;
      took[1] = v[1] && bus.req1_ready;
      @(posedge clk);
      #1;
      if (took[0]) begin void'(q0.pop_front()); v[0] = 1'b0; end
      if (took[1]) begin void'(q1.pop_front()); v[1] = 1'b0; end
      if (!v[0]) present(0);
      if (!v[1]) present(1);
    end
  end

  // Response consumer back-pressure.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: bus.rsp_ready = 1'b1;
        1: bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  logic       m_busy = 1'b0;
  logic       m_lg = 1'b1;
  int         m_acc = 0;
  logic [2:0] m_op = 3'd0;
  logic [7:0] m_a = 8'd0;
  logic [7:0] m_b = 8'd0;
  rsp_t       h = '{1'b0, 8'd0, 1'b0};

  // Monitor: predict this cycle's outputs, compare, then advance the model.
  always @(negedge clk) begin
    logic e0, e1, erv, g;
    e0 = 1'b0; e1 = 1'b0; g = 1'b0;
    if (!rst && !m_busy && (v[0] || v[1])) begin
      if (v[0] && v[1]) g = RR ? ~m_lg : 1'b0;
      else g = v[1];
      e0 = !g;
      e1 = g;
    end
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    chk("alu_a", bus.alu_a, m_a);
    chk("alu_b", bus.alu_b, m_b);
    chk("alu_a_m", bus.alu_a_m, m_a[3:0]);
    chk("alu_b_m", bus.alu_b_m, m_b[3:0]);
    chk("alu_opcode", bus.alu_opcode, m_op);
    erv = m_busy && (cyc >= m_acc + LAT + 1);
    if (erv && exp_q.size() > 0) h = exp_q[0];
    chk("rsp_valid", bus.rsp_valid, erv);
    chk("rsp_id", bus.rsp_id, h.id);
    chk("rsp_result", bus.rsp_result, h.res);
    chk("rsp_flag", bus.rsp_flag, h.flag);
    if (rst) begin
      m_busy = 1'b0; m_lg = 1'b1; m_op = 3'd0; m_a = 8'd0; m_b = 8'd0;
      h = '{1'b0, 8'd0, 1'b0};
      exp_q.delete();
    end else if (erv && bus.rsp_ready) begin
      log_q.push_back('{bus.rsp_id, bus.rsp_result, bus.rsp_flag});
      void'(exp_q.pop_front());
      m_busy = 1'b0;
    end else if (e0 || e1) begin
      m_op = opc[g]; m_a = oa[g]; m_b = ob[g];
      exp_q.push_back(ref_rsp(g, int'(opc[g]), int'(oa[g]), int'(ob[g])));
      m_busy = 1'b1; m_lg = g; m_acc = cyc;
    end
    cyc++;
  end

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !v[0] && !v[1] && !m_busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  task automatic wait_busy();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (m_busy) begin seen = 1'b1; break; end
    end
    chk("accept_timeout", seen, 1'b1);
  endtask

  task automatic chk_log(input string name, input int idx, input logic id,
                         input logic [7:0] res, input logic f);
    if (log_q.size() > idx) begin
      chk({name, "_id"}, log_q[idx].id, id);
      chk({name, "_result"}, log_q[idx].res, res);
      chk({name, "_flag"}, log_q[idx].flag, f);
    end else begin
      chk({name, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    int base;
    logic [7:0] first_res;
    op_t t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    base = log_q.size();
    q0.push_back('{3'd0, 8'd5, 8'd3, 0});
    drain();
    chk_log("add_5_3", base, 1'b0, 8'd8, 1'b0);

    base = log_q.size();
    q0.push_back('{3'd0, 8'd225, 8'd50, 0});
    q1.push_back('{3'd1, 8'd100, 8'd205, 0});
    drain();
    chk_log("contend_first", base, 1'b0, 8'd19, 1'b1);
    chk_log("contend_second", base + 1, 1'b1, 8'd151, 1'b1);

    base = log_q.size();
    q1.push_back('{3'd2, 8'h1F, 8'hAF, 0});
    wait_busy();
    @(negedge clk);
    chk("mul_alu_a_m", bus.alu_a_m, 4'd15);
    chk("mul_alu_b_m", bus.alu_b_m, 4'd15);
    drain();
    chk_log("mul", base, 1'b1, 8'd225, 1'b0);

    base = log_q.size();
    rr_mode = 2;
    q0.push_back('{3'd1, 8'd9, 8'd4, 0});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    chk("stall_rsp_seen", bus.rsp_valid, 1'b1);
    first_res = bus.rsp_result;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold_valid", bus.rsp_valid, 1'b1);
      chk("stall_hold_result", bus.rsp_result, first_res);
    end
    rr_mode = 0;
    drain();
    chk_log("stall", base, 1'b0, 8'd5, 1'b0);

    base = log_q.size();
    q0.push_back('{3'd0, 8'd1, 8'd2, 0});
    wait_busy();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_alu_a", bus.alu_a, 8'd0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (LAT + 4) @(posedge clk);
    chk("rst_no_rsp", log_q.size(), base);

    base = log_q.size();
    for (int i = 0; i < 4; i++) q0.push_back('{3'd3, 8'(8'h30 + i), 8'hF0, 0});
    q1.push_back('{3'd4, 8'h0F, 8'h10, 0});
    drain();
`ifndef ALU_SCHED_RR_EN
    for (int i = 0; i < 4; i++) chk("fixed_prio_id", log_q[base + i].id, 1'b0);
    chk("fixed_prio_last", log_q[base + 4].id, 1'b1);
`endif
    chk("fixed_prio_count", log_q.size(), base + 5);

    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      t.op = 3'($urandom_range(0, 7));
      t.a = 8'($urandom_range(0, 255));
      t.b = 8'($urandom_range(0, 255));
      t.gap = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) q0.push_back(t);
      else q1.push_back(t);
    end
    drain();
    rr_mode = 0;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
